// File: rtl/ddr_cmd_arbiter.sv
// Two-requester round-robin arbiter that hands one command at a time to
// either the AXI read engine or the AXI write engine and reports completion.
module ddr_cmd_arbiter #(
    parameter int unsigned ADDR_WIDTH      = 29,
    parameter int unsigned BURST_LEN_WIDTH = 8,
    parameter int unsigned NUM_BURST_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rstn,

    input  logic                       req0_valid,
    input  logic                       req0_rw,
    input  logic [ADDR_WIDTH-1:0]      req0_addr,
    input  logic [BURST_LEN_WIDTH-1:0] req0_burst_len,
    input  logic [NUM_BURST_WIDTH-1:0] req0_num_burst,
    output logic                       req0_ack,
    output logic                       req0_done,

    input  logic                       req1_valid,
    input  logic                       req1_rw,
    input  logic [ADDR_WIDTH-1:0]      req1_addr,
    input  logic [BURST_LEN_WIDTH-1:0] req1_burst_len,
    input  logic [NUM_BURST_WIDTH-1:0] req1_num_burst,
    output logic                       req1_ack,
    output logic                       req1_done,

    output logic                       rd_start,
    output logic [BURST_LEN_WIDTH-1:0] rd_burst_len,
    output logic [NUM_BURST_WIDTH-1:0] rd_num_burst,
    output logic [ADDR_WIDTH-1:0]      rd_start_addr,
    input  logic                       rd_ready,
    input  logic                       rd_done,

    output logic                       wr_start,
    output logic [BURST_LEN_WIDTH-1:0] wr_burst_len,
    output logic [NUM_BURST_WIDTH-1:0] wr_num_burst,
    output logic [ADDR_WIDTH-1:0]      wr_start_addr,
    input  logic                       wr_ready,
    input  logic                       wr_done,

    output logic                       busy,
    output logic                       grant_id
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t                     state, state_n;

    logic                       cap_rw, cap_rw_n;
    logic [ADDR_WIDTH-1:0]      cap_addr, cap_addr_n;
    logic [BURST_LEN_WIDTH-1:0] cap_len, cap_len_n;
    logic [NUM_BURST_WIDTH-1:0] cap_nb, cap_nb_n;
    logic                       cap_id, cap_id_n;
    logic                       imm_done, imm_done_n;
    logic                       last_grant, last_grant_n;

    logic                       req0_ack_n, req1_ack_n;
    logic                       req0_done_n, req1_done_n;
    logic                       rd_start_n, wr_start_n;
    logic                       busy_n, grant_id_n;
    logic [BURST_LEN_WIDTH-1:0] len_n;
    logic [NUM_BURST_WIDTH-1:0] nb_n;
    logic [ADDR_WIDTH-1:0]      addr_n;

    logic                       win;
    logic                       eng_done;

    // Next-state, capture and output-next logic
    always_comb begin
        state_n      = state;
        cap_rw_n     = cap_rw;
        cap_addr_n   = cap_addr;
        cap_len_n    = cap_len;
        cap_nb_n     = cap_nb;
        cap_id_n     = cap_id;
        imm_done_n   = imm_done;
        last_grant_n = last_grant;
        req0_ack_n   = 1'b0;
        req1_ack_n   = 1'b0;
        req0_done_n  = 1'b0;
        req1_done_n  = 1'b0;
        rd_start_n   = 1'b0;
        wr_start_n   = 1'b0;

        // Tie goes to whoever was not served last; a lone requester always wins
        if (req0_valid && req1_valid) begin
            win = ~last_grant;
        end else begin
            win = req1_valid;
        end

        // An engine cannot finish in the cycle it is started, so done is masked then
        if (cap_rw) begin
            eng_done = wr_done && !wr_start;
        end else begin
            eng_done = rd_done && !rd_start;
        end

        case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    cap_id_n   = win;
                    imm_done_n = 1'b0;
                    state_n    = ISSUE;
                    if (win) begin
                        cap_rw_n   = req1_rw;
                        cap_addr_n = req1_addr;
                        cap_len_n  = req1_burst_len;
                        cap_nb_n   = req1_num_burst;
                        req1_ack_n = 1'b1;
                    end else begin
                        cap_rw_n   = req0_rw;
                        cap_addr_n = req0_addr;
                        cap_len_n  = req0_burst_len;
                        cap_nb_n   = req0_num_burst;
                        req0_ack_n = 1'b1;
                    end
                end
            end

            ISSUE: begin
                if (cap_nb == '0) begin
                    imm_done_n = 1'b1;
                    state_n    = WAIT_DONE;
                end else if (!cap_rw && rd_ready) begin
                    rd_start_n = 1'b1;
                    state_n    = WAIT_DONE;
                end else if (cap_rw && wr_ready) begin
                    wr_start_n = 1'b1;
                    state_n    = WAIT_DONE;
                end
            end

            WAIT_DONE: begin
                if (imm_done || eng_done) begin
                    req0_done_n  = ~cap_id;
                    req1_done_n  = cap_id;
                    last_grant_n = cap_id;
                    imm_done_n   = 1'b0;
                    state_n      = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        // Command fields are presented only while a command is owned
        busy_n     = (state_n != IDLE);
        grant_id_n = busy_n ? cap_id_n : 1'b0;
        addr_n     = busy_n ? cap_addr_n : '0;
        len_n      = busy_n ? cap_len_n : '0;
        nb_n       = busy_n ? cap_nb_n : '0;
    end

    // State, captured command and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            cap_rw        <= 1'b0;
            cap_addr      <= '0;
            cap_len       <= '0;
            cap_nb        <= '0;
            cap_id        <= 1'b0;
            imm_done      <= 1'b0;
            last_grant    <= 1'b1;
            req0_ack      <= 1'b0;
            req1_ack      <= 1'b0;
            req0_done     <= 1'b0;
            req1_done     <= 1'b0;
            rd_start      <= 1'b0;
            wr_start      <= 1'b0;
            rd_start_addr <= '0;
            rd_burst_len  <= '0;
            rd_num_burst  <= '0;
            wr_start_addr <= '0;
            wr_burst_len  <= '0;
            wr_num_burst  <= '0;
            busy          <= 1'b0;
            grant_id      <= 1'b0;
        end else begin
            state         <= state_n;
            cap_rw        <= cap_rw_n;
            cap_addr      <= cap_addr_n;
            cap_len       <= cap_len_n;
            cap_nb        <= cap_nb_n;
            cap_id        <= cap_id_n;
            imm_done      <= imm_done_n;
            last_grant    <= last_grant_n;
            req0_ack      <= req0_ack_n;
            req1_ack      <= req1_ack_n;
            req0_done     <= req0_done_n;
            req1_done     <= req1_done_n;
            rd_start      <= rd_start_n;
            wr_start      <= wr_start_n;
            rd_start_addr <= addr_n;
            rd_burst_len  <= len_n;
            rd_num_burst  <= nb_n;
            wr_start_addr <= addr_n;
            wr_burst_len  <= len_n;
            wr_num_burst  <= nb_n;
            busy          <= busy_n;
            grant_id      <= grant_id_n;
        end
    end

endmodule

// File: tb/tb_ddr_cmd_arbiter.sv
// Scoreboard bench for ddr_cmd_arbiter: expected grants, engine starts and
// completions are queued as stimulus is driven and checked as the DUT emits them.
module tb_ddr_cmd_arbiter;

    localparam int unsigned AW = 29;
    localparam int unsigned LW = 8;
    localparam int unsigned NW = 8;

    typedef struct packed {
        logic          rw;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic [NW-1:0] nb;
    } cmd_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic          req0_valid, req0_rw, req0_ack, req0_done;
    logic [AW-1:0] req0_addr;
    logic [LW-1:0] req0_burst_len;
    logic [NW-1:0] req0_num_burst;
    logic          req1_valid, req1_rw, req1_ack, req1_done;
    logic [AW-1:0] req1_addr;
    logic [LW-1:0] req1_burst_len;
    logic [NW-1:0] req1_num_burst;
    logic          rd_start, rd_ready, rd_done;
    logic [LW-1:0] rd_burst_len;
    logic [NW-1:0] rd_num_burst;
    logic [AW-1:0] rd_start_addr;
    logic          wr_start, wr_ready, wr_done;
    logic [LW-1:0] wr_burst_len;
    logic [NW-1:0] wr_num_burst;
    logic [AW-1:0] wr_start_addr;
    logic          busy, grant_id;

    logic man_rd_done, man_wr_done, auto_rd_done, auto_wr_done, auto_en;
    assign rd_done = man_rd_done | auto_rd_done;
    assign wr_done = man_wr_done | auto_wr_done;

    int   checks = 0;
    int   errors = 0;
    int   ack_cnt = 0;
    int   done_cnt = 0;
    int   start_cnt = 0;
    cmd_t exp_start[$];
    logic exp_ack[$];
    logic exp_done[$];

    always #5 clk = ~clk;

    ddr_cmd_arbiter #(.ADDR_WIDTH(AW), .BURST_LEN_WIDTH(LW), .NUM_BURST_WIDTH(NW)) dut (
        .clk(clk), .rstn(rstn),
        .req0_valid(req0_valid), .req0_rw(req0_rw), .req0_addr(req0_addr),
        .req0_burst_len(req0_burst_len), .req0_num_burst(req0_num_burst),
        .req0_ack(req0_ack), .req0_done(req0_done),
        .req1_valid(req1_valid), .req1_rw(req1_rw), .req1_addr(req1_addr),
        .req1_burst_len(req1_burst_len), .req1_num_burst(req1_num_burst),
        .req1_ack(req1_ack), .req1_done(req1_done),
        .rd_start(rd_start), .rd_burst_len(rd_burst_len), .rd_num_burst(rd_num_burst),
        .rd_start_addr(rd_start_addr), .rd_ready(rd_ready), .rd_done(rd_done),
        .wr_start(wr_start), .wr_burst_len(wr_burst_len), .wr_num_burst(wr_num_burst),
        .wr_start_addr(wr_start_addr), .wr_ready(wr_ready), .wr_done(wr_done),
        .busy(busy), .grant_id(grant_id)
    );

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Pops the scoreboard whenever the DUT emits an ack, start or done
    task automatic monitor();
        cmd_t e;
        logic id;
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (req0_ack || req1_ack) begin
                    ack_cnt++;
                    checks++;
                    id = exp_ack.size() != 0 ? exp_ack.pop_front() : 1'bx;
                    if ({req0_ack, req1_ack, grant_id} !== {~id, id, id}) begin
                        errors++;
                        $display("FAIL ack: got ack0=%b ack1=%b grant_id=%b, want id %b",
                                 req0_ack, req1_ack, grant_id, id);
                    end
                end
                if (req0_done || req1_done) begin
                    done_cnt++;
                    checks++;
                    id = exp_done.size() != 0 ? exp_done.pop_front() : 1'bx;
                    if ({req0_done, req1_done} !== {~id, id}) begin
                        errors++;
                        $display("FAIL done: got done0=%b done1=%b, want id %b",
                                 req0_done, req1_done, id);
                    end
                end
                if (rd_start || wr_start) begin
                    start_cnt++;
                    checks++;
                    e = exp_start.size() != 0 ? exp_start.pop_front() : 'x;
                    if (rd_start && wr_start) begin
                        errors++;
                        $display("FAIL start_excl: rd_start and wr_start both high");
                    end else if (rd_start &&
                        ({1'b0, rd_start_addr, rd_burst_len, rd_num_burst} !== e)) begin
                        errors++;
                        $display("FAIL rd_start: got addr=%h len=%0d nb=%0d, want rw=%b addr=%h len=%0d nb=%0d",
                                 rd_start_addr, rd_burst_len, rd_num_burst, e.rw, e.addr, e.len, e.nb);
                    end else if (wr_start &&
                        ({1'b1, wr_start_addr, wr_burst_len, wr_num_burst} !== e)) begin
                        errors++;
                        $display("FAIL wr_start: got addr=%h len=%0d nb=%0d, want rw=%b addr=%h len=%0d nb=%0d",
                                 wr_start_addr, wr_burst_len, wr_num_burst, e.rw, e.addr, e.len, e.nb);
                    end
                end
                if (!busy && ({rd_start_addr, rd_burst_len, rd_num_burst,
                               wr_start_addr, wr_burst_len, wr_num_burst} !== '0)) begin
                    checks++;
                    errors++;
                    $display("FAIL idle_fields: engine fields nonzero while idle rd_addr=%h wr_addr=%h",
                             rd_start_addr, wr_start_addr);
                end
            end
        end
    endtask

    // Simple engine model: completes each started command two cycles later
    task automatic responder();
        int rc = 0;
        int wc = 0;
        forever begin
            @(negedge clk);
            auto_rd_done = 1'b0;
            auto_wr_done = 1'b0;
            if (!rstn || !auto_en) begin
                rc = 0;
                wc = 0;
            end else begin
                if (rd_start) rc = 2;
                else if (rc != 0) begin
                    rc--;
                    if (rc == 0) auto_rd_done = 1'b1;
                end
                if (wr_start) wc = 2;
                else if (wc != 0) begin
                    wc--;
                    if (wc == 0) auto_wr_done = 1'b1;
                end
            end
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        step();
        step();
        rstn = 1'b1;
        step();
    endtask

    task automatic wait_done(input int target, input string name);
        for (int n = 0; n < 300 && done_cnt < target; n++) step();
        checks++;
        if (done_cnt < target || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: done_cnt=%0d busy=%b, want done_cnt=%0d busy=0",
                     name, done_cnt, busy, target);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({req0_ack, req0_done, req1_ack, req1_done, rd_start, wr_start, busy, grant_id,
             rd_start_addr, wr_start_addr, rd_burst_len, wr_num_burst} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b grant=%b rd_addr=%h, want all zero",
                     busy, grant_id, rd_start_addr);
        end
    endtask

    task automatic test_basic_read();
        int d0;
        do_reset();
        d0 = done_cnt;
        auto_en = 1'b0;
        rd_ready = 1'b1;
        exp_ack.push_back(1'b0);
        exp_start.push_back('{1'b0, AW'('h100), LW'(16), NW'(4)});
        exp_done.push_back(1'b0);
        req0_valid = 1'b1; req0_rw = 1'b0; req0_addr = AW'('h100);
        req0_burst_len = LW'(16); req0_num_burst = NW'(4);
        step();
        checks++;
        if (req0_ack !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_ack_latency: ack0=%b busy=%b, want 1 1", req0_ack, busy);
        end
        req0_valid = 1'b0;
        step();
        checks++;
        if (rd_start !== 1'b1) begin
            errors++;
            $display("FAIL basic_start_latency: rd_start=%b, want 1", rd_start);
        end
        man_rd_done = 1'b1;
        step();
        man_rd_done = 1'b0;
        checks++;
        if (req0_done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_coincident_done: done0=%b busy=%b, want 0 1", req0_done, busy);
        end
        step();
        man_rd_done = 1'b1;
        step();
        man_rd_done = 1'b0;
        checks++;
        if (req0_done !== 1'b1 || busy !== 1'b0 || done_cnt != d0 + 1) begin
            errors++;
            $display("FAIL basic_done_latency: done0=%b busy=%b, want 1 0", req0_done, busy);
        end
    endtask

    task automatic test_round_robin();
        int k0 = 0;
        int k1 = 0;
        int d0;
        do_reset();
        d0 = done_cnt;
        auto_en = 1'b1;
        rd_ready = 1'b1;
        wr_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            exp_ack.push_back(1'b0);
            exp_ack.push_back(1'b1);
            exp_done.push_back(1'b0);
            exp_done.push_back(1'b1);
            exp_start.push_back('{1'b0, AW'('h200 + i * 'h40), LW'(4), NW'(1 + i)});
            exp_start.push_back('{1'b1, AW'('h800 + i * 'h40), LW'(8), NW'(3 + i)});
        end
        req0_valid = 1'b1; req0_rw = 1'b0; req0_addr = AW'('h200);
        req0_burst_len = LW'(4); req0_num_burst = NW'(1);
        req1_valid = 1'b1; req1_rw = 1'b1; req1_addr = AW'('h800);
        req1_burst_len = LW'(8); req1_num_burst = NW'(3);
        for (int n = 0; n < 400 && (k0 < 2 || k1 < 2); n++) begin
            step();
            // Changing the pending request right after ack must not alter the in-flight one
            if (req0_ack) begin
                k0++;
                if (k0 == 2) req0_valid = 1'b0;
                req0_addr = AW'('h200 + k0 * 'h40);
                req0_num_burst = NW'(1 + k0);
            end
            if (req1_ack) begin
                k1++;
                if (k1 == 2) req1_valid = 1'b0;
                req1_addr = AW'('h800 + k1 * 'h40);
                req1_num_burst = NW'(3 + k1);
            end
        end
        wait_done(d0 + 4, "rr_complete");
    endtask

    task automatic test_wr_stall();
        int d0;
        do_reset();
        d0 = done_cnt;
        auto_en = 1'b1;
        wr_ready = 1'b0;
        exp_ack.push_back(1'b1);
        exp_start.push_back('{1'b1, AW'('h3000), LW'(8), NW'(2)});
        exp_done.push_back(1'b1);
        req1_valid = 1'b1; req1_rw = 1'b1; req1_addr = AW'('h3000);
        req1_burst_len = LW'(8); req1_num_burst = NW'(2);
        step();
        req1_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (wr_start !== 1'b0 || busy !== 1'b1 || grant_id !== 1'b1 ||
                wr_start_addr !== AW'('h3000) || wr_burst_len !== LW'(8) ||
                wr_num_burst !== NW'(2)) begin
                errors++;
                $display("FAIL stall_hold: wr_start=%b busy=%b addr=%h len=%0d nb=%0d, want 0 1 3000 8 2",
                         wr_start, busy, wr_start_addr, wr_burst_len, wr_num_burst);
            end
        end
        wr_ready = 1'b1;
        step();
        checks++;
        if (wr_start !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: wr_start=%b, want 1", wr_start);
        end
        wait_done(d0 + 1, "stall_complete");
    endtask

    task automatic test_zero_burst();
        int d0;
        int s0;
        do_reset();
        d0 = done_cnt;
        s0 = start_cnt;
        rd_ready = 1'b1;
        wr_ready = 1'b1;
        exp_ack.push_back(1'b0);
        exp_done.push_back(1'b0);
        req0_valid = 1'b1; req0_rw = 1'b1; req0_addr = AW'('h44);
        req0_burst_len = LW'(2); req0_num_burst = NW'(0);
        step();
        req0_valid = 1'b0;
        wait_done(d0 + 1, "zero_burst_done");
        checks++;
        if (start_cnt != s0) begin
            errors++;
            $display("FAIL zero_burst_nostart: starts=%0d, want %0d", start_cnt, s0);
        end
    endtask

    task automatic test_wrong_engine_done();
        int d0;
        do_reset();
        d0 = done_cnt;
        auto_en = 1'b0;
        wr_ready = 1'b1;
        exp_ack.push_back(1'b1);
        exp_start.push_back('{1'b1, AW'('h1_0000), LW'(32), NW'(1)});
        exp_done.push_back(1'b1);
        req1_valid = 1'b1; req1_rw = 1'b1; req1_addr = AW'('h1_0000);
        req1_burst_len = LW'(32); req1_num_burst = NW'(1);
        step();
        req1_valid = 1'b0;
        step();
        step();
        man_rd_done = 1'b1;
        step();
        man_rd_done = 1'b0;
        step();
        step();
        checks++;
        if (busy !== 1'b1 || done_cnt != d0) begin
            errors++;
            $display("FAIL wrong_engine_done: busy=%b dones=%0d, want 1 %0d", busy, done_cnt, d0);
        end
        man_wr_done = 1'b1;
        step();
        man_wr_done = 1'b0;
        checks++;
        if (req1_done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL wr_done_accept: done1=%b busy=%b, want 1 0", req1_done, busy);
        end
    endtask

    task automatic test_reset_in_flight();
        int d0;
        do_reset();
        auto_en = 1'b0;
        wr_ready = 1'b1;
        exp_ack.push_back(1'b0);
        exp_start.push_back('{1'b1, AW'('h5000), LW'(4), NW'(2)});
        req0_valid = 1'b1; req0_rw = 1'b1; req0_addr = AW'('h5000);
        req0_burst_len = LW'(4); req0_num_burst = NW'(2);
        step();
        req0_valid = 1'b0;
        step();
        step();
        rstn = 1'b0;
        #1;
        checks++;
        if ({req0_ack, req0_done, req1_ack, req1_done, rd_start, wr_start, busy, grant_id,
             wr_start_addr, wr_burst_len, wr_num_burst} !== '0) begin
            errors++;
            $display("FAIL async_reset: busy=%b wr_addr=%h, want all zero", busy, wr_start_addr);
        end
        step();
        rstn = 1'b1;
        d0 = done_cnt;
        step();
        man_wr_done = 1'b1;
        step();
        man_wr_done = 1'b0;
        step();
        step();
        checks++;
        if (done_cnt != d0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stray_done: dones=%0d busy=%b, want %0d 0", done_cnt, busy, d0);
        end
        exp_ack.push_back(1'b0);
        exp_ack.push_back(1'b1);
        exp_done.push_back(1'b0);
        exp_done.push_back(1'b1);
        req0_num_burst = NW'(0);
        req1_valid = 1'b1; req1_rw = 1'b0; req1_num_burst = NW'(0);
        req0_valid = 1'b1;
        for (int n = 0; n < 100 && (req0_valid || req1_valid); n++) begin
            step();
            if (req0_ack) req0_valid = 1'b0;
            if (req1_ack) req1_valid = 1'b0;
        end
        wait_done(d0 + 2, "post_reset_tie");
    endtask

    initial begin
        rstn = 1'b0;
        req0_valid = 1'b0; req0_rw = 1'b0; req0_addr = '0; req0_burst_len = '0; req0_num_burst = '0;
        req1_valid = 1'b0; req1_rw = 1'b0; req1_addr = '0; req1_burst_len = '0; req1_num_burst = '0;
        rd_ready = 1'b0; wr_ready = 1'b0;
        man_rd_done = 1'b0; man_wr_done = 1'b0;
        auto_rd_done = 1'b0; auto_wr_done = 1'b0; auto_en = 1'b0;
        fork
            monitor();
            responder();
        join_none

        test_reset();
        test_basic_read();
        test_round_robin();
        test_wr_stall();
        test_zero_burst();
        test_wrong_engine_done();
        test_reset_in_flight();
        step();

        checks++;
        if (exp_ack.size() != 0 || exp_start.size() != 0 || exp_done.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: pending ack=%0d start=%0d done=%0d, want 0 0 0",
                     exp_ack.size(), exp_start.size(), exp_done.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddr_cmd_arbiter.md
DDR_CMD_ARBITER -- requirements
Module: ddr_cmd_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 29, DDR byte address width.
REQ-002 SHALL have parameter BURST_LEN_WIDTH, default 8, AXI burst length field width.
REQ-003 SHALL have parameter NUM_BURST_WIDTH, default 8, burst count field width.
REQ-004 SHALL have port clk  in  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port rstn  in  1  asynchronous active-low reset.
REQ-006 SHALL have, for N in {0,1}, port reqN_valid  in  1  requester N command pending.
REQ-007 SHALL have reqN_rw  in  1  0 = read, 1 = write.
REQ-008 SHALL have reqN_addr  in  ADDR_WIDTH  start address.
REQ-009 SHALL have reqN_burst_len  in  BURST_LEN_WIDTH  beats per burst.
REQ-010 SHALL have reqN_num_burst  in  NUM_BURST_WIDTH  bursts in command.
REQ-011 SHALL have reqN_ack  out  1  one-cycle pulse: command captured.
REQ-012 SHALL have reqN_done  out  1  one-cycle pulse: command completed.
REQ-013 SHALL have rd_start  out  1; rd_burst_len  out  BURST_LEN_WIDTH; rd_num_burst  out  NUM_BURST_WIDTH; rd_start_addr  out  ADDR_WIDTH; rd_ready  in  1; rd_done  in  1 (AXI read engine).
REQ-014 SHALL have the identical wr_* port set toward the AXI write engine.
REQ-015 SHALL have busy  out  1 (state != IDLE) and grant_id  out  1 (owner of current command).

Function
REQ-016 SHALL implement FSM IDLE -> ISSUE -> WAIT_DONE -> IDLE, one state per cycle minimum.
REQ-017 IDLE: if any reqN_valid, SHALL grant, capture rw/addr/burst_len/num_burst of winner into registers, pulse reqN_ack of winner for exactly that cycle, set grant_id, go ISSUE.
REQ-018 Arbitration SHALL be round-robin: both valid -> grant the requester not granted last; last_grant resets to 1 so req0 wins first tie.
REQ-019 Single valid requester SHALL be granted regardless of last_grant.
REQ-020 ISSUE, captured num_burst == 0: SHALL skip engines, go WAIT_DONE with an internal immediate-done flag; no rd_start/wr_start.
REQ-021 ISSUE, rw=0: SHALL wait until rd_ready=1, then pulse rd_start one cycle, go WAIT_DONE; rw=1 likewise with wr_ready/wr_start.
REQ-022 rd_/wr_ burst_len, num_burst, start_addr SHALL be driven from captured registers, stable from ISSUE entry to WAIT_DONE exit; zero while IDLE.
REQ-023 WAIT_DONE: SHALL wait for the engine's done matching captured rw (or immediate-done flag), then pulse reqN_done of grant_id for one cycle, update last_grant, return IDLE.
REQ-024 done of the non-selected engine, or any done outside WAIT_DONE, SHALL be ignored.
REQ-025 done coincident with start cycle SHALL be ignored; only done in WAIT_DONE counts.
REQ-026 reqN_valid changes after ack SHALL not affect the in-flight command; a still-asserted valid is a new request.
REQ-027 Grant-to-start latency SHALL be 1 cycle when engine ready; done-to-reqN_done latency 1 cycle; next grant earliest the cycle after IDLE re-entry.
REQ-028 At most one of rd_start, wr_start SHALL be high in any cycle; at most one command in flight.

Reset
REQ-029 rstn low SHALL immediately force state IDLE, all outputs 0, captured registers 0, last_grant 1, regardless of in-flight command.
REQ-030 After reset release, a done from a command started before reset SHALL be ignored (state IDLE).

Verification
REQ-031 req0 valid rw=0 addr=0x100 len=16 nb=4, rd_ready=1 -> req0_ack cycle 1, rd_start cycle 2 with 0x100/16/4; rd_done -> req0_done next cycle.
REQ-032 req0 and req1 valid continuously, alternating rw -> grants 0,1,0,1; wr_start only for rw=1 commands.
REQ-033 req1 write, wr_ready low 10 cycles -> wr_start held off until wr_ready=1; outputs stable throughout.
REQ-034 nb=0 request -> ack, then done without any rd_start/wr_start.
REQ-035 rd_done pulsed during a write in WAIT_DONE -> ignored; req done only on wr_done.
REQ-036 rstn low in WAIT_DONE, then release and stray wr_done -> all outputs 0, no reqN_done, next tie grants req0.
